// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 capture sink: pixel bit order,
// status word bit positions and the copy FSM state encoding.
package hub75_pkg;

   typedef struct packed {
      logic b1;
      logic g1;
      logic r1;
      logic b0;
      logic g0;
      logic r0;
   } pixel_t;

   localparam int ST_OVERRUN   = 16;
   localparam int ST_SHORT     = 17;
   localparam int ST_LONG      = 18;
   localparam int ST_BUSY      = 19;
   localparam int ST_OE        = 20;
   localparam int ST_FRAME_LSB = 24;

   typedef enum logic {
      IDLE = 1'b0,
      COPY = 1'b1
   } copy_state_e;

endpackage

// File: rtl/hub75_sink_if.sv
// Simple memory-mapped bus used to read the HUB75 capture memory and status.
// Handshake: ren/wen are one-cycle strobes qualified by addr; when addr decodes
// (active=1) ready pulses exactly one cycle later and rdata is valid in that cycle.
interface hub75_sink_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        wen;
   logic        ren;
   logic [31:0] rdata;
   logic        ready;
   logic        active;

   modport master (
      output addr, wdata, wmask, wen, ren,
      input  rdata, ready, active
   );

   modport slave (
      input  addr, wdata, wmask, wen, ren,
      output rdata, ready, active
   );
endinterface

// File: rtl/hub75_sync.sv
// Two-flop synchronizer; every HUB75 input uses this same depth so that
// data, row address and strobes arrive in the clk domain together.
module hub75_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/hub75_sink.sv
// HUB75 panel sink: captures shifted rows into a memory readable over the bus.
// Optional HUB75_SINK_FRAME_CNT_EN adds a frame counter in status [31:24].
module hub75_sink
   import hub75_pkg::*;
#(
   parameter int          ROWS     = 64,
   parameter int          COLS     = 64,
   parameter logic [31:0] BASEADDR = 32'h8200_0000,
   localparam int         ROWS_2   = ROWS / 2,
   localparam int         RW       = $clog2(ROWS_2)
) (
   input  logic          clk,
   input  logic          rst,
   hub75_sink_if.slave   bus,
   input  logic          R0,
   input  logic          G0,
   input  logic          B0,
   input  logic          R1,
   input  logic          G1,
   input  logic          B1,
   input  logic [RW-1:0] ROWSEL,
   input  logic          CLK_HUB75,
   input  logic          LATCH,
   input  logic          OE
);
   localparam int NPIX = ROWS_2 * COLS;
   localparam int AW   = $clog2(NPIX);
   localparam int CW   = $clog2(COLS + 1);
   localparam int IW   = $clog2(COLS);

   logic          r0_s, g0_s, b0_s, r1_s, g1_s, b1_s;
   logic [RW-1:0] rowsel_s;
   logic          hclk_s, latch_s, oe_s;

   hub75_sync #(.W(1))  u_sync_r0    (.clk(clk), .rst(rst), .d(R0),        .q(r0_s));
   hub75_sync #(.W(1))  u_sync_g0    (.clk(clk), .rst(rst), .d(G0),        .q(g0_s));
   hub75_sync #(.W(1))  u_sync_b0    (.clk(clk), .rst(rst), .d(B0),        .q(b0_s));
   hub75_sync #(.W(1))  u_sync_r1    (.clk(clk), .rst(rst), .d(R1),        .q(r1_s));
   hub75_sync #(.W(1))  u_sync_g1    (.clk(clk), .rst(rst), .d(G1),        .q(g1_s));
   hub75_sync #(.W(1))  u_sync_b1    (.clk(clk), .rst(rst), .d(B1),        .q(b1_s));
   hub75_sync #(.W(RW)) u_sync_row   (.clk(clk), .rst(rst), .d(ROWSEL),    .q(rowsel_s));
   hub75_sync #(.W(1))  u_sync_hclk  (.clk(clk), .rst(rst), .d(CLK_HUB75), .q(hclk_s));
   hub75_sync #(.W(1))  u_sync_latch (.clk(clk), .rst(rst), .d(LATCH),     .q(latch_s));
   hub75_sync #(.W(1))  u_sync_oe    (.clk(clk), .rst(rst), .d(OE),        .q(oe_s));

   pixel_t        pix_s;
   logic          hclk_d, latch_d;
   logic          shift_rise, latch_rise, shift_ok, take_snap;
   logic [CW-1:0] shift_cnt, shift_cnt_nx;
   logic [15:0]   latch_cnt;
   logic          overrun, short_err, long_err;
   copy_state_e   state, state_nx;
   logic [IW-1:0] idx, idx_nx;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   pixel_t        shreg   [COLS];
   pixel_t        row_buf [COLS];
   logic [RW-1:0] row_buf_sel;
   pixel_t        mem     [NPIX];

   assign pix_s = {b1_s, g1_s, r1_s, b0_s, g0_s, r0_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hclk_d  <= 1'b0;
         latch_d <= 1'b0;
      end else begin
         hclk_d  <= hclk_s;
         latch_d <= latch_s;
      end
   end

   assign shift_rise   = hclk_s & ~hclk_d;
   assign latch_rise   = latch_s & ~latch_d;
   assign shift_ok     = shift_rise && (shift_cnt < CW'(COLS));
   assign shift_cnt_nx = shift_ok ? shift_cnt + CW'(1) : shift_cnt;
   assign take_snap    = latch_rise && (state == IDLE);

   // A shift landing in the latch cycle is folded into the snapshot directly.
   always_ff @(posedge clk) begin
      if (shift_ok)
         shreg[shift_cnt[IW-1:0]] <= pix_s;
      if (take_snap) begin
         for (int i = 0; i < COLS; i++)
            row_buf[i] <= (shift_ok && shift_cnt == CW'(i)) ? pix_s : shreg[i];
         row_buf_sel <= rowsel_s;
      end
   end

   // Bus decode
   logic [31:0] offset;
   logic [29:0] word_idx;
   logic        in_range, is_status, status_wr;
   logic [31:0] status_word;
   pixel_t      rd_pix;

   assign offset    = bus.addr - BASEADDR;
   assign in_range  = (bus.addr >= BASEADDR) && (offset < 32'(4 * (NPIX + 1)));
   assign word_idx  = offset[31:2];
   assign is_status = (word_idx == 30'(NPIX));
   assign status_wr = in_range && bus.wen && is_status && bus.wmask[2];
   assign rd_pix    = mem[word_idx[AW-1:0]];
   assign bus.active = in_range;

   logic set_overrun, set_short, set_long;
   logic clr_overrun, clr_short, clr_long;

   assign set_overrun = latch_rise && (state == COPY);
   assign set_short   = latch_rise && (shift_cnt_nx != CW'(COLS));
   assign set_long    = shift_rise && (shift_cnt == CW'(COLS));
   assign clr_overrun = status_wr && bus.wdata[ST_OVERRUN];
   assign clr_short   = status_wr && bus.wdata[ST_SHORT];
   assign clr_long    = status_wr && bus.wdata[ST_LONG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_cnt <= '0;
         latch_cnt <= '0;
         overrun   <= 1'b0;
         short_err <= 1'b0;
         long_err  <= 1'b0;
      end else begin
         shift_cnt <= latch_rise ? '0 : shift_cnt_nx;
         if (latch_rise)
            latch_cnt <= latch_cnt + 16'd1;
         overrun   <= set_overrun | (overrun   & ~clr_overrun);
         short_err <= set_short   | (short_err & ~clr_short);
         long_err  <= set_long    | (long_err  & ~clr_long);
      end
   end

`ifdef HUB75_SINK_FRAME_CNT_EN
   logic [7:0] frame_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         frame_cnt <= '0;
      else if (take_snap && rowsel_s == RW'(ROWS_2 - 1))
         frame_cnt <= frame_cnt + 8'd1;
   end
`endif

   // Copy FSM: drains the row buffer into memory one pixel per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      mem_we   = 1'b0;
      case (state)
         IDLE: begin
            if (latch_rise) begin
               state_nx = COPY;
               idx_nx   = '0;
            end
         end
         COPY: begin
            mem_we = 1'b1;
            idx_nx = idx + IW'(1);
            if (idx == IW'(COLS - 1))
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign mem_waddr = AW'(row_buf_sel) * AW'(COLS) + AW'(idx);

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_waddr] <= row_buf[idx];
   end

   always_comb begin
      status_word              = '0;
      status_word[15:0]        = latch_cnt;
      status_word[ST_OVERRUN]  = overrun;
      status_word[ST_SHORT]    = short_err;
      status_word[ST_LONG]     = long_err;
      status_word[ST_BUSY]     = (state == COPY);
      status_word[ST_OE]       = ~oe_s;
`ifdef HUB75_SINK_FRAME_CNT_EN
      status_word[ST_FRAME_LSB +: 8] = frame_cnt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rdata <= '0;
         bus.ready <= 1'b0;
      end else begin
         bus.ready <= in_range && (bus.ren || bus.wen);
         if (in_range && bus.ren)
            bus.rdata <= is_status ? status_word : {26'b0, rd_pix};
         else
            bus.rdata <= '0;
      end
   end

   logic unused_bus;
   assign unused_bus = ^{bus.wdata[31:19], bus.wdata[15:0], bus.wmask[3], bus.wmask[1:0]};

endmodule
